// File: rtl/lcd_vbuf_write_arbiter.sv
// lcd_vbuf_write_arbiter
// Merges two Game Boy pixel streams into the single write port of the shared
// LCD frame RAM. Each stream is tagged with its running frame address and
// queued in a small FIFO. A round-robin arbiter drains the FIFOs at no more
// than one RAM write per clock. wr_addr[15] selects the frame buffer
// (0 = core 1, 1 = core 2).

module lcd_vbuf_write_arbiter #(
    parameter int DATA_W       = 15,
    parameter int FIFO_AW      = 2,
    parameter int FRAME_PIXELS = 23040
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce1,
    input  logic [DATA_W-1:0] data1,
    input  logic [1:0]        mode1,
    input  logic              on1,
    input  logic              ce2,
    input  logic [DATA_W-1:0] data2,
    input  logic [1:0]        mode2,
    input  logic              on2,
    output logic              wr_en,
    output logic [15:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done1,
    output logic              frame_done2,
    output logic              ovf1,
    output logic              ovf2
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam int               ENTRY_W   = 15 + DATA_W;
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] ZERO_CNT  = (FIFO_AW+1)'(0);
    localparam logic [14:0]      LAST_ADDR = 15'(FRAME_PIXELS - 1);

    // Port inputs gathered into arrays so both requesters share one code path.
    logic [1:0]        ce_s;
    logic [1:0]        on_s;
    logic [1:0]        vbl_s;
    logic [DATA_W-1:0] din_s [2];

    // FIFO storage and per-port state.
    logic [ENTRY_W-1:0] mem_r [2][DEPTH];
    logic [FIFO_AW-1:0] wp_r  [2];
    logic [FIFO_AW-1:0] rp_r  [2];
    logic [FIFO_AW:0]   cnt_r [2];
    logic [14:0]        ptr_r [2];
    logic [1:0]         fd_r;
    logic [1:0]         ovf_r;
    logic               rr_last_r;   // 0 = core 1 served last, 1 = core 2

    // Per-cycle decisions.
    logic [1:0]         full_s;
    logic [1:0]         valid_s;
    logic [1:0]         accept_s;
    logic [1:0]         push_s;
    logic [1:0]         drop_s;
    logic [1:0]         pop_s;
    logic               gnt_s;
    logic               gnt_port_s;
    logic [ENTRY_W-1:0] head_s;

    assign ce_s     = {ce2, ce1};
    assign on_s     = {on2, on1};
    assign vbl_s    = {(mode2 == 2'b01), (mode1 == 2'b01)};
    assign din_s[0] = data1;
    assign din_s[1] = data2;

    assign frame_done1 = fd_r[0];
    assign frame_done2 = fd_r[1];
    assign ovf1        = ovf_r[0];
    assign ovf2        = ovf_r[1];

    // FIFO status from start-of-cycle counts; a disabled port offers nothing to drain.
    always_comb begin
        full_s   = 2'b00;
        valid_s  = 2'b00;
        accept_s = 2'b00;
        push_s   = 2'b00;
        drop_s   = 2'b00;
        for (int p = 0; p < 2; p++) begin
            full_s[p]   = (cnt_r[p] == FULL_CNT);
            valid_s[p]  = (cnt_r[p] != ZERO_CNT) && on_s[p];
            accept_s[p] = on_s[p] && !vbl_s[p] && ce_s[p];
            push_s[p]   = accept_s[p] && !full_s[p];
            drop_s[p]   = accept_s[p] && full_s[p];
        end
    end

    // Round-robin grant: on a tie the port that was not served last wins.
    always_comb begin
        gnt_s      = 1'b0;
        gnt_port_s = 1'b0;
        if (valid_s[0] && valid_s[1]) begin
            gnt_s      = 1'b1;
            gnt_port_s = ~rr_last_r;
        end else if (valid_s[0]) begin
            gnt_s      = 1'b1;
            gnt_port_s = 1'b0;
        end else if (valid_s[1]) begin
            gnt_s      = 1'b1;
            gnt_port_s = 1'b1;
        end else begin
            gnt_s      = 1'b0;
            gnt_port_s = 1'b0;
        end
        pop_s  = {gnt_s && gnt_port_s, gnt_s && !gnt_port_s};
        head_s = mem_r[gnt_port_s][rp_r[gnt_port_s]];
    end

    // FIFO storage writes: each entry is {frame address, pixel}.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                mem_r[p][wp_r[p]] <= {ptr_r[p], din_s[p]};
            end
        end
    end

    // Enqueue address pointers, FIFO bookkeeping, frame-done pulses and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                ptr_r[p] <= 15'd0;
                wp_r[p]  <= {FIFO_AW{1'b0}};
                rp_r[p]  <= {FIFO_AW{1'b0}};
                cnt_r[p] <= ZERO_CNT;
            end
            fd_r  <= 2'b00;
            ovf_r <= 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!on_s[p]) begin
                    // LCD off: restart the frame and discard everything queued.
                    ptr_r[p] <= 15'd0;
                    wp_r[p]  <= {FIFO_AW{1'b0}};
                    rp_r[p]  <= {FIFO_AW{1'b0}};
                    cnt_r[p] <= ZERO_CNT;
                    fd_r[p]  <= 1'b0;
                end else begin
                    if (vbl_s[p]) begin
                        ptr_r[p] <= 15'd0;
                    end else if (ce_s[p]) begin
                        ptr_r[p] <= (ptr_r[p] == LAST_ADDR) ? 15'd0 : ptr_r[p] + 15'd1;
                    end else begin
                        ptr_r[p] <= ptr_r[p];
                    end
                    fd_r[p] <= accept_s[p] && (ptr_r[p] == LAST_ADDR);
                    if (drop_s[p]) begin
                        ovf_r[p] <= 1'b1;
                    end else begin
                        ovf_r[p] <= ovf_r[p];
                    end
                    if (push_s[p]) begin
                        wp_r[p] <= wp_r[p] + {{(FIFO_AW-1){1'b0}}, 1'b1};
                    end else begin
                        wp_r[p] <= wp_r[p];
                    end
                    if (pop_s[p]) begin
                        rp_r[p] <= rp_r[p] + {{(FIFO_AW-1){1'b0}}, 1'b1};
                    end else begin
                        rp_r[p] <= rp_r[p];
                    end
                    cnt_r[p] <= cnt_r[p] + {{FIFO_AW{1'b0}}, push_s[p]}
                                         - {{FIFO_AW{1'b0}}, pop_s[p]};
                end
            end
        end
    end

    // Registered RAM write port; address and data hold while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= {DATA_W{1'b0}};
            rr_last_r <= 1'b1;
        end else if (gnt_s) begin
            wr_en     <= 1'b1;
            wr_addr   <= {gnt_port_s, head_s[ENTRY_W-1 -: 15]};
            wr_data   <= head_s[DATA_W-1:0];
            rr_last_r <= gnt_port_s;
        end else begin
            wr_en     <= 1'b0;
            wr_addr   <= wr_addr;
            wr_data   <= wr_data;
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: tb/tb_lcd_vbuf_write_arbiter.sv
// Testbench for lcd_vbuf_write_arbiter: directed table, hand sequences for the
// frame-wrap / LCD-off / vblank / reset corners, and a randomized run, all
// compared every cycle against a queue-based reference model.

module tb_lcd_vbuf_write_arbiter;

    localparam int FP = 23040;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce1 = 1'b0, on1 = 1'b0, ce2 = 1'b0, on2 = 1'b0;
    logic [14:0] data1 = 15'd0, data2 = 15'd0;
    logic [1:0]  mode1 = 2'b11, mode2 = 2'b11;
    logic        wr_en, frame_done1, frame_done2, ovf1, ovf2;
    logic [15:0] wr_addr;
    logic [14:0] wr_data;

    lcd_vbuf_write_arbiter #(.DATA_W(15), .FIFO_AW(2), .FRAME_PIXELS(FP)) dut (
        .clk(clk), .reset(reset),
        .ce1(ce1), .data1(data1), .mode1(mode1), .on1(on1),
        .ce2(ce2), .data2(data2), .mode2(mode2), .on2(on2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done1(frame_done1), .frame_done2(frame_done2),
        .ovf1(ovf1), .ovf2(ovf2)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { int addr; int data; } ent_t;
    ent_t q0[$];
    ent_t q1[$];
    int   m_ptr [2];
    bit   m_ovf [2];
    bit   m_fd  [2];
    bit   m_en;
    int   m_addr, m_data;
    int   m_rr;

    int pass_cnt = 0, tot_cnt = 0;
    int wlog_addr[$];
    int wlog_data[$];
    int fd2_cnt = 0;

    function automatic void model_reset();
        q0.delete(); q1.delete();
        for (int p = 0; p < 2; p++) begin
            m_ptr[p] = 0; m_ovf[p] = 0; m_fd[p] = 0;
        end
        m_en = 0; m_addr = 0; m_data = 0; m_rr = 1;
    endfunction

    function automatic void model_step();
        int   s0 = q0.size();
        int   s1 = q1.size();
        bit   v0 = (s0 > 0) && on1;
        bit   v1 = (s1 > 0) && on2;
        int   g  = -1;
        ent_t e;
        if (v0 && v1) g = (m_rr == 1) ? 0 : 1;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        if (g == 0) begin
            e = q0.pop_front(); m_en = 1; m_addr = e.addr; m_data = e.data; m_rr = 0;
        end else if (g == 1) begin
            e = q1.pop_front(); m_en = 1; m_addr = 32'h8000 | e.addr; m_data = e.data; m_rr = 1;
        end else begin
            m_en = 0;
        end
        // core 1
        if (!on1) begin
            q0.delete(); m_ptr[0] = 0; m_fd[0] = 0;
        end else if (mode1 == 2'b01) begin
            m_ptr[0] = 0; m_fd[0] = 0;
        end else if (ce1) begin
            if (s0 < 4) q0.push_back('{m_ptr[0], int'(data1)});
            else        m_ovf[0] = 1;
            m_fd[0]  = (m_ptr[0] == FP - 1);
            m_ptr[0] = (m_ptr[0] + 1) % FP;
        end else begin
            m_fd[0] = 0;
        end
        // core 2
        if (!on2) begin
            q1.delete(); m_ptr[1] = 0; m_fd[1] = 0;
        end else if (mode2 == 2'b01) begin
            m_ptr[1] = 0; m_fd[1] = 0;
        end else if (ce2) begin
            if (s1 < 4) q1.push_back('{m_ptr[1], int'(data2)});
            else        m_ovf[1] = 1;
            m_fd[1]  = (m_ptr[1] == FP - 1);
            m_ptr[1] = (m_ptr[1] + 1) % FP;
        end else begin
            m_fd[1] = 0;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check("wr_en",       32'(wr_en),       32'(m_en));
        check("wr_addr",     32'(wr_addr),     m_addr);
        check("wr_data",     32'(wr_data),     m_data);
        check("frame_done1", 32'(frame_done1), 32'(m_fd[0]));
        check("frame_done2", 32'(frame_done2), 32'(m_fd[1]));
        check("ovf1",        32'(ovf1),        32'(m_ovf[0]));
        check("ovf2",        32'(ovf2),        32'(m_ovf[1]));
        if (wr_en === 1'b1) begin
            wlog_addr.push_back(int'(wr_addr));
            wlog_data.push_back(int'(wr_data));
        end
        if (frame_done2 === 1'b1) fd2_cnt++;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_wr_en",   32'(wr_en),       32'd0);
        check("rst_wr_addr", 32'(wr_addr),     32'd0);
        check("rst_ovf1",    32'(ovf1),        32'd0);
        check("rst_ovf2",    32'(ovf2),        32'd0);
        check("rst_fd1",     32'(frame_done1), 32'd0);
        check("rst_fd2",     32'(frame_done2), 32'd0);
        model_reset();
        ce1 = 1'b0; ce2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wlog_addr.delete(); wlog_data.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        ce1; logic [14:0] d1;
        logic        ce2; logic [14:0] d2;
        logic        en;  logic [15:0] addr; logic [14:0] data;
    } vec_t;
    vec_t tv [9];

    initial begin
        tv[0] = '{1'b1, 15'h0AAA, 1'b0, 15'h0000, 1'b0, 16'h0000, 15'h0000};
        tv[1] = '{1'b1, 15'h0BBB, 1'b0, 15'h0000, 1'b1, 16'h0000, 15'h0AAA};
        tv[2] = '{1'b1, 15'h0CCC, 1'b0, 15'h0000, 1'b1, 16'h0001, 15'h0BBB};
        tv[3] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 16'h0002, 15'h0CCC};
        tv[4] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 16'h0002, 15'h0CCC};
        tv[5] = '{1'b1, 15'h1111, 1'b1, 15'h2222, 1'b0, 16'h0002, 15'h0CCC};
        tv[6] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 16'h8000, 15'h2222};
        tv[7] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 16'h0003, 15'h1111};
        tv[8] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 16'h0003, 15'h1111};

        model_reset();
        do_reset();

        // 1: three-pixel burst and round-robin tie
        on1 = 1'b1; mode1 = 2'b11; on2 = 1'b1; mode2 = 2'b11;
        for (int i = 0; i < 9; i++) begin
            ce1 = tv[i].ce1; data1 = tv[i].d1;
            ce2 = tv[i].ce2; data2 = tv[i].d2;
            cycle();
            check($sformatf("tbl%0d_en", i),   32'(wr_en),   32'(tv[i].en));
            check($sformatf("tbl%0d_addr", i), 32'(wr_addr), 32'(tv[i].addr));
            check($sformatf("tbl%0d_data", i), 32'(wr_data), 32'(tv[i].data));
        end
        ce1 = 1'b0; ce2 = 1'b0;

        // 2: both cores strobe every clock for 8 clocks
        do_reset();
        on1 = 1'b1; mode1 = 2'b11; on2 = 1'b1; mode2 = 2'b11;
        for (int i = 0; i < 8; i++) begin
            ce1 = 1'b1; data1 = 15'(16'h0100 + i);
            ce2 = 1'b1; data2 = 15'(16'h0200 + i);
            cycle();
        end
        ce1 = 1'b0; ce2 = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_ovf1", 32'(ovf1), 32'd1);
        check("t2_ovf2", 32'(ovf2), 32'd1);
        check("t2_writes", wlog_addr.size(), 14);
        for (int k = 0; k < 8 && k < wlog_addr.size(); k++)
            check($sformatf("t2_alt%0d", k), (wlog_addr[k] >> 15) & 1, k % 2);

        // 3: full frame on core 2 with wrap
        do_reset();
        on1 = 1'b0; on2 = 1'b1; mode2 = 2'b11;
        fd2_cnt = 0;
        for (int i = 0; i < FP; i++) begin
            ce2 = 1'b1; data2 = 15'($urandom);
            cycle();
            ce2 = 1'b0;
            cycle();
        end
        for (int i = 0; i < 3; i++) cycle();
        check("t3_nwrites", wlog_addr.size(), FP);
        check("t3_last", wlog_addr.size() > 0 ? wlog_addr[$] : -1, 32'h0000D9FF);
        check("t3_fd2_cnt", fd2_cnt, 1);
        ce2 = 1'b1; data2 = 15'h1234;
        cycle();
        ce2 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t3_wrap", wlog_addr.size() > 0 ? wlog_addr[$] : -1, 32'h00008000);

        // 4: LCD off flushes queued pixels
        do_reset();
        on1 = 1'b1; mode1 = 2'b11; on2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce1 = 1'b1; data1 = 15'(16'h0040 + i);
            cycle();
        end
        ce1 = 1'b0; on1 = 1'b0;
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 4; i++) cycle();
        check("t4_no_writes", wlog_addr.size(), 0);
        on1 = 1'b1; ce1 = 1'b1; data1 = 15'h0123;
        cycle();
        ce1 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t4_nwrites", wlog_addr.size(), 1);
        check("t4_addr", wlog_addr.size() > 0 ? wlog_addr[0] : -1, 0);
        check("t4_data", wlog_data.size() > 0 ? wlog_data[0] : -1, 32'h0123);

        // 5: vblank resets the pointer but queued pixels still drain
        do_reset();
        on1 = 1'b1; mode1 = 2'b11; on2 = 1'b0;
        ce1 = 1'b1; data1 = 15'h0051; cycle();
        ce1 = 1'b1; data1 = 15'h0052; cycle();
        ce1 = 1'b0; mode1 = 2'b01;    cycle();
        mode1 = 2'b11; ce1 = 1'b1; data1 = 15'h0058; cycle();
        ce1 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t5_nwrites", wlog_addr.size(), 3);
        if (wlog_addr.size() == 3) begin
            check("t5_a0", wlog_addr[0], 0);
            check("t5_a1", wlog_addr[1], 1);
            check("t5_a2", wlog_addr[2], 0);
            check("t5_dx", wlog_data[2], 32'h0058);
        end

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            on1   = ($urandom_range(0, 99) < 96);
            on2   = ($urandom_range(0, 99) < 96);
            mode1 = ($urandom_range(0, 99) < 5) ? 2'b01 : 2'($urandom_range(2, 3));
            mode2 = ($urandom_range(0, 99) < 5) ? 2'b01 : 2'($urandom_range(2, 3));
            ce1   = ($urandom_range(0, 99) < 60);
            ce2   = ($urandom_range(0, 99) < 60);
            data1 = 15'($urandom);
            data2 = 15'($urandom);
            cycle();
        end

        // 6: asynchronous reset in the middle of the burst
        do_reset();
        on1 = 1'b1; mode1 = 2'b11; on2 = 1'b1; mode2 = 2'b11;
        ce1 = 1'b1; data1 = 15'h0777;
        cycle();
        ce1 = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("t6_nwrites", wlog_addr.size(), 1);
        check("t6_addr", wlog_addr.size() > 0 ? wlog_addr[0] : -1, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
